// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and helpers (TX and RX)
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  function automatic int default_div(input int clock_freq_hz, input int baud_rate);
    return clock_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with wrap-flag pointers
module uart_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8,
  localparam int AW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // MSB is the lap flag: equal index with differing laps means full.
  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter with parity and runtime divisor
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int      ClockFreqHz = 10000000,
  parameter int      BaudRate    = 9600,
  parameter int      DataBits    = 8,
  parameter parity_e ParityMode  = PARITY_NONE,
  parameter int      StopBits    = 1,
  parameter int      FifoDepth   = 8,
  localparam int     LevelW      = $clog2(FifoDepth) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DataBits-1:0] write_data,
  input  logic                write,
  output logic                write_ready,
  input  logic [15:0]         baud_div,
  output logic                tx_sig,
  output logic                busy,
  output logic [LevelW-1:0]   fifo_level
);

  localparam logic [15:0] DefaultDiv = 16'(default_div(ClockFreqHz, BaudRate));
  localparam logic [3:0]  LastBit    = 4'(DataBits - 1);

  if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
    $error("uart_tx_buffered: DataBits must be 5..9");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_stop_bits
    $error("uart_tx_buffered: StopBits must be 1..2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: FifoDepth must be a power of two >= 2");
  end

  uart_tx_state_e      state;
  logic                ready_en;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic [DataBits-1:0] fifo_rdata;
  logic [DataBits-1:0] shift_q;
  logic                parity_q;
  logic [15:0]         div_q;
  logic [15:0]         div_now;
  logic [16:0]         cnt_q;
  logic [16:0]         bit_load;
  logic [16:0]         stop_load;
  logic [3:0]          bit_cnt;
  logic                bit_done;

  function automatic logic frame_parity(input logic [DataBits-1:0] d);
    return (ParityMode == PARITY_ODD) ? ~^d : ^d;
  endfunction

  uart_sync_fifo #(
    .Width(DataBits),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (write && write_ready),
    .wdata (write_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // ready_en keeps write_ready low until the first edge after reset release.
  assign write_ready = ready_en && !fifo_full;
  assign busy        = (state != IDLE) || (fifo_level != '0);
  assign div_now     = (baud_div == 16'd0) ? DefaultDiv : baud_div;
  assign bit_done    = (cnt_q == 17'd0);
  assign bit_load    = {1'b0, div_q} - 17'd1;
  assign stop_load   = (StopBits == 2) ? ({div_q, 1'b0} - 17'd1) : ({1'b0, div_q} - 17'd1);
  assign pop         = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_sig   <= 1'b1;
      ready_en <= 1'b0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      bit_cnt  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (pop) begin
        // A new frame starts from IDLE or straight out of the last stop cycle.
        state    <= START;
        tx_sig   <= 1'b0;
        shift_q  <= fifo_rdata;
        parity_q <= frame_parity(fifo_rdata);
        div_q    <= div_now;
        cnt_q    <= {1'b0, div_now} - 17'd1;
        bit_cnt  <= '0;
      end else begin
        case (state)
          IDLE: tx_sig <= 1'b1;
          START: begin
            if (bit_done) begin
              state  <= DATA;
              tx_sig <= shift_q[0];
              cnt_q  <= bit_load;
            end else begin
              cnt_q <= cnt_q - 17'd1;
            end
          end
          DATA: begin
            if (!bit_done) begin
              cnt_q <= cnt_q - 17'd1;
            end else if (bit_cnt != LastBit) begin
              shift_q <= shift_q >> 1;
              tx_sig  <= shift_q[1];
              bit_cnt <= bit_cnt + 4'd1;
              cnt_q   <= bit_load;
            end else if (ParityMode != PARITY_NONE) begin
              state  <= PARITY;
              tx_sig <= parity_q;
              cnt_q  <= bit_load;
            end else begin
              state  <= STOP;
              tx_sig <= 1'b1;
              cnt_q  <= stop_load;
            end
          end
          PARITY: begin
            if (bit_done) begin
              state  <= STOP;
              tx_sig <= 1'b1;
              cnt_q  <= stop_load;
            end else begin
              cnt_q <= cnt_q - 17'd1;
            end
          end
          STOP: begin
            if (bit_done) begin
              state <= IDLE;
            end else begin
              cnt_q <= cnt_q - 17'd1;
            end
          end
          default: begin
            state  <= IDLE;
            tx_sig <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Parametrised UART transmitter; successor to the single-byte UART TX.
- Adds an internal TX FIFO, 5–9 data bits, parity (none/even/odd), 1 or 2 stop bits, and a runtime baud divisor.
- Back-to-back frames are sent with no idle gap.
- Sits between the CPU's memory-mapped UART register block and the board TX pin.

Parameters:
- ClockFreqHz, 10000000, system clock frequency.
- BaudRate, 9600, default baud; DefaultDiv = ClockFreqHz / BaudRate.
- DataBits, 8, data bits per frame; legal 5..9.
- ParityMode, PARITY_NONE, parity_e: NONE, EVEN or ODD.
- StopBits, 1, stop bits per frame; legal 1..2.
- FifoDepth, 8, TX FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- write_data  in  DataBits  byte to queue.
- write  in  1  push request.
- write_ready  out  1  FIFO not full; a push occurs on a clock edge where write && write_ready.
- baud_div  in  16  clocks per bit; 0 selects DefaultDiv.
- tx_sig  out  1  serial line, idle high.
- busy  out  1  FIFO non-empty or frame in progress.
- fifo_level  out  $clog2(FifoDepth)+1  current FIFO occupancy.

Behaviour:
- Reset: asynchronous, active-low; clk rising edge. While rst_n is low:
  - tx_sig=1, write_ready=0, busy=0, fifo_level=0.
  - FIFO emptied; FSM in IDLE.
  - write_ready goes to 1 on the first edge after release.
- Reset mid-frame: tx_sig returns high immediately (asynchronously). The partial frame and all queued data are discarded.
- write_ready = !full, derived from registered state only. It carries no combinational path from write.
- Push while full cannot occur, since write_ready=0. A pop and a push in the same cycle are both performed; level is unchanged.
- Divisor: D = (baud_div==0) ? DefaultDiv : baud_div. D is latched at the frame start. Changes mid-frame take effect at the next frame.
- Every bit (start, data, parity, stop) holds tx_sig for exactly D cycles, timed by a down-counter loaded with D-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty → pop, load shift register, latch D, tx_sig=0, go to START.
  - START: after D cycles → DATA; drive bit 0.
  - DATA: LSB first; after D cycles per bit advance bit_cnt. After bit DataBits-1: → PARITY if ParityMode!=NONE, else → STOP.
  - PARITY: bit = ^data for EVEN, ~^data for ODD; D cycles → STOP.
  - STOP: tx_sig=1 for StopBits*D cycles. At the end: if FIFO non-empty, pop and go straight to START, with tx_sig=0 on the very next cycle. Otherwise go to IDLE.
  - Any illegal state → IDLE with tx_sig=1.
- Latency: with write accepted at edge N into an empty FIFO, tx_sig falls after edge N+1.
- Frame length in clocks is exactly D*(1+DataBits+P+StopBits), where P=1 if parity is enabled.
- busy = (state!=IDLE) || fifo_level!=0.
- FIFO pointers are $clog2(FifoDepth)+1 bits wide with an MSB wrap flag. full and empty are decoded from the pointers; they wrap modulo 2*FifoDepth.
- Parameter legality is checked at elaboration: $error if DataBits∉5..9, StopBits∉1..2, or FifoDepth is not a power of two.

Decomposition:
- Package uart_pkg holds:
  - parity_e (PARITY_NONE, PARITY_EVEN, PARITY_ODD);
  - uart_tx_state_e;
  - function default_div(ClockFreqHz, BaudRate), shared with the future RX block.
- One sub-module: uart_sync_fifo (parametrised Width, Depth; push/pop/full/empty/level; async active-low reset). It is also reused by RX.
- Framing FSM and baud counter stay in uart_tx_buffered.

Test Plan:
- Reset/idle: hold rst_n low 5 cycles, then release → tx_sig=1, busy=0, fifo_level=0; write_ready=0 during reset and 1 one edge after release.
- 8N1 single byte: baud_div=4, push 0xA5 → tx_sig low 4 clk, then bits 1,0,1,0,0,1,0,1 at 4 clk each, then high 4 clk. Frame = 40 clk; busy drops immediately after.
- Back-to-back plus full FIFO: FifoDepth=8, push 9 bytes 0x00..0x08 continuously → write_ready=0 once level=8, the 9th accepted after the first pop. Frames are contiguous (stop high exactly D, then next start) and bytes come out in order.
- Parity/width: DataBits=7, ParityMode=ODD, StopBits=2, baud_div=3, push 0x55 → 7 data bits 1010101, parity bit 1 (four ones, odd parity adds a 1), 6 clk high. Frame = 33 clk.
- Divisor: baud_div=0 with defaults → each bit lasts 1041 clk. Changing baud_div from 4 to 8 mid-frame leaves the current frame at 4 clk/bit; the next frame uses 8.
- Reset mid-frame: assert rst_n low during DATA with 3 bytes queued → tx_sig=1 asynchronously, fifo_level=0. After release no further frames are sent.
